// File: rtl/intctrl_prio.sv
// rtl/intctrl_prio.sv - priority interrupt controller with edge latches and round-robin tie-break
module intctrl_prio #(
    parameter int ARCHBITSZ   = 32,
    parameter int INTSRCCOUNT = 8,
    parameter int INTDSTCOUNT = 2,
    parameter int PRIOBITSZ   = 2
) (
    input  logic                                     clk_i,
    input  logic                                     rst_i,
    input  logic [1:0]                               pi1_op_i,
    input  logic [ARCHBITSZ-$clog2(ARCHBITSZ/8)-1:0] pi1_addr_i,
    input  logic [ARCHBITSZ-1:0]                     pi1_data_i,
    output logic [ARCHBITSZ-1:0]                     pi1_data_o,
    input  logic [ARCHBITSZ/8-1:0]                   pi1_sel_i,
    output logic                                     pi1_rdy_o,
    output logic [ARCHBITSZ-1:0]                     pi1_mapsz_o,
    output logic [INTDSTCOUNT-1:0]                   intrqstdst_o,
    input  logic [INTDSTCOUNT-1:0]                   intrdydst_i,
    input  logic [INTDSTCOUNT-1:0]                   intbestdst_i,
    input  logic [INTSRCCOUNT-1:0]                   intrqstsrc_i,
    output logic [INTSRCCOUNT-1:0]                   intrdysrc_o
);

    localparam int SRCW   = (INTSRCCOUNT > 1) ? $clog2(INTSRCCOUNT) : 1;
    localparam int DSTW   = (INTDSTCOUNT > 1) ? $clog2(INTDSTCOUNT) : 1;
    localparam int MAPMUL = ((64 / ARCHBITSZ) > 0) ? (64 / ARCHBITSZ) : 1;

    localparam logic [1:0] PIRWOP     = 2'b11;
    localparam logic [2:0] CMD_ACKINT = 3'd0;
    localparam logic [2:0] CMD_INTDST = 3'd1;
    localparam logic [2:0] CMD_CFGSRC = 3'd2;

    localparam logic [ARCHBITSZ-1:0] RET_NEG1 = '1;
    localparam logic [ARCHBITSZ-1:0] RET_NEG2 = {{(ARCHBITSZ-1){1'b1}}, 1'b0};

    localparam logic [ARCHBITSZ-5:0]           ACK_DST_LIM = (ARCHBITSZ-4)'(INTDSTCOUNT);
    localparam logic [ARCHBITSZ-4:0]           INT_DST_LIM = (ARCHBITSZ-3)'(INTDSTCOUNT);
    localparam logic [ARCHBITSZ-6-PRIOBITSZ:0] CFG_IDX_LIM = (ARCHBITSZ-5-PRIOBITSZ)'(INTSRCCOUNT);
    localparam logic [SRCW-1:0]                SRC_LAST    = SRCW'(INTSRCCOUNT-1);
    localparam logic [DSTW-1:0]                DST_LAST    = DSTW'(INTDSTCOUNT-1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEEK,
        ST_PEND
    } state_t;

    state_t                 state_q, state_d;
    logic [SRCW-1:0]        rrptr_q, rrptr_d;
    logic [SRCW-1:0]        cursrc_q, cursrc_d;
    logic [DSTW-1:0]        dstidx_q, dstidx_d;
    logic [DSTW-1:0]        target_q, target_d;
    logic                   forced_q, forced_d;
    logic [INTDSTCOUNT-1:0] dsten_q, dsten_d;
    logic [INTSRCCOUNT-1:0] srcen_q, srcen_d;
    logic [INTSRCCOUNT-1:0] srcedge_q, srcedge_d;
    logic [INTSRCCOUNT-1:0] latch_q, latch_d;
    logic [INTSRCCOUNT-1:0] prev_q;
    logic [PRIOBITSZ-1:0]   prio_q [INTSRCCOUNT];
    logic [PRIOBITSZ-1:0]   prio_d [INTSRCCOUNT];
    logic [ARCHBITSZ-1:0]   data_q, data_d;

    logic [2:0]                      cmd;
    logic                            cmd_valid;
    logic                            ack_en;
    logic [ARCHBITSZ-5:0]            ack_dst;
    logic [ARCHBITSZ-4:0]            int_dst;
    logic [PRIOBITSZ-1:0]            cfg_prio;
    logic                            cfg_edge;
    logic                            cfg_en;
    logic [ARCHBITSZ-6-PRIOBITSZ:0]  cfg_idx;

    logic [INTSRCCOUNT-1:0] elig;
    logic [INTSRCCOUNT-1:0] rise;
    logic [INTSRCCOUNT-1:0] latch_clr;
    logic                   any_best;
    logic                   dst_ok;
    logic [DSTW-1:0]        dst_step;

    logic                   pick_valid;
    logic [SRCW-1:0]        pick_idx;
    logic [PRIOBITSZ-1:0]   pick_prio;
    logic [SRCW:0]          scan_sum;
    logic [SRCW-1:0]        scan_idx;

    logic unused_ok;
    assign unused_ok = ^{pi1_addr_i, pi1_sel_i};

    function automatic logic [SRCW-1:0] src_inc(input logic [SRCW-1:0] s);
        return (s == SRC_LAST) ? '0 : s + 1'b1;
    endfunction

    function automatic logic [DSTW-1:0] dst_inc(input logic [DSTW-1:0] d);
        return (d == DST_LAST) ? '0 : d + 1'b1;
    endfunction

    assign cmd       = pi1_data_i[2:0];
    assign cmd_valid = (pi1_op_i == PIRWOP);
    assign ack_en    = pi1_data_i[3];
    assign ack_dst   = pi1_data_i[ARCHBITSZ-1:4];
    assign int_dst   = pi1_data_i[ARCHBITSZ-1:3];
    assign cfg_prio  = pi1_data_i[3 +: PRIOBITSZ];
    assign cfg_edge  = pi1_data_i[3+PRIOBITSZ];
    assign cfg_en    = pi1_data_i[4+PRIOBITSZ];
    assign cfg_idx   = pi1_data_i[ARCHBITSZ-1:5+PRIOBITSZ];

    assign elig     = srcen_q & ((srcedge_q & latch_q) | (~srcedge_q & intrqstsrc_i));
    assign rise     = intrqstsrc_i & ~prev_q;
    assign any_best = |(intbestdst_i & dsten_q);
    assign dst_ok   = dsten_q[dstidx_q] &
                      ((~any_best & intrdydst_i[dstidx_q]) | intbestdst_i[dstidx_q]);

    // Scan in round-robin order starting at rrptr; strict > keeps the earliest tie.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        pick_prio  = '0;
        scan_sum   = '0;
        scan_idx   = '0;
        for (int k = 0; k < INTSRCCOUNT; k++) begin
            scan_sum = {1'b0, rrptr_q} + (SRCW+1)'(k);
            if (scan_sum >= (SRCW+1)'(INTSRCCOUNT)) begin
                scan_sum = scan_sum - (SRCW+1)'(INTSRCCOUNT);
            end
            scan_idx = scan_sum[SRCW-1:0];
            if (elig[scan_idx] && (!pick_valid || (prio_q[scan_idx] > pick_prio))) begin
                pick_valid = 1'b1;
                pick_idx   = scan_idx;
                pick_prio  = prio_q[scan_idx];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        rrptr_d   = rrptr_q;
        cursrc_d  = cursrc_q;
        dstidx_d  = dstidx_q;
        target_d  = target_q;
        forced_d  = forced_q;
        dsten_d   = dsten_q;
        srcen_d   = srcen_q;
        srcedge_d = srcedge_q;
        prio_d    = prio_q;
        data_d    = data_q;
        latch_clr = '0;
        dst_step  = dstidx_q;

        if (cmd_valid) begin
            case (cmd)
                CMD_ACKINT: begin
                    if ((state_q == ST_PEND) && (ack_dst == (ARCHBITSZ-4)'(dstidx_q))) begin
                        data_d = forced_q ? RET_NEG1 : ARCHBITSZ'(cursrc_q);
                        if (!forced_q) begin
                            latch_clr[cursrc_q] = srcedge_q[cursrc_q];
                            rrptr_d             = src_inc(cursrc_q);
                        end
                        dstidx_d = '0;
                        forced_d = 1'b0;
                        state_d  = ST_IDLE;
                    end else begin
                        data_d = RET_NEG2;
                    end
                    if (ack_dst < ACK_DST_LIM) begin
                        dsten_d[ack_dst[DSTW-1:0]] = ack_en;
                    end
                end
                CMD_INTDST: begin
                    if (int_dst >= INT_DST_LIM) begin
                        data_d = RET_NEG1;
                    end else if (state_q != ST_IDLE) begin
                        data_d = RET_NEG2;
                    end else begin
                        data_d   = ARCHBITSZ'(int_dst);
                        target_d = int_dst[DSTW-1:0];
                        forced_d = 1'b1;
                        dstidx_d = '0;
                        state_d  = ST_SEEK;
                    end
                end
                CMD_CFGSRC: begin
                    if (cfg_idx < CFG_IDX_LIM) begin
                        prio_d[cfg_idx[SRCW-1:0]]    = cfg_prio;
                        srcedge_d[cfg_idx[SRCW-1:0]] = cfg_edge;
                        srcen_d[cfg_idx[SRCW-1:0]]   = cfg_en;
                        data_d                       = ARCHBITSZ'(cfg_idx);
                    end else begin
                        data_d = RET_NEG1;
                    end
                end
                default: data_d = RET_NEG1;
            endcase
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pick_valid) begin
                        cursrc_d = pick_idx;
                        forced_d = 1'b0;
                        state_d  = ST_SEEK;
                    end
                end
                ST_SEEK: begin
                    if (forced_q) begin
                        dst_step = (dstidx_q == target_q) ? dstidx_q : dst_inc(dstidx_q);
                        dstidx_d = dst_step;
                        if (dst_step == target_q) begin
                            state_d = ST_PEND;
                        end
                    end else if (!elig[cursrc_q]) begin
                        dstidx_d = '0;
                        state_d  = ST_IDLE;
                    end else if (dst_ok) begin
                        state_d = ST_PEND;
                    end else begin
                        dstidx_d = dst_inc(dstidx_q);
                    end
                end
                ST_PEND: state_d = ST_PEND;
                default: state_d = ST_IDLE;
            endcase
        end

        // A new edge outranks an acknowledge clear; disabling always wins.
        latch_d = ((latch_q & ~latch_clr) | (rise & srcen_q)) & srcen_d;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            rrptr_q   <= '0;
            cursrc_q  <= '0;
            dstidx_q  <= '0;
            target_q  <= '0;
            forced_q  <= 1'b0;
            dsten_q   <= '0;
            srcen_q   <= '0;
            srcedge_q <= '0;
            latch_q   <= '0;
            prev_q    <= '0;
            data_q    <= '0;
            for (int i = 0; i < INTSRCCOUNT; i++) begin
                prio_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            rrptr_q   <= rrptr_d;
            cursrc_q  <= cursrc_d;
            dstidx_q  <= dstidx_d;
            target_q  <= target_d;
            forced_q  <= forced_d;
            dsten_q   <= dsten_d;
            srcen_q   <= srcen_d;
            srcedge_q <= srcedge_d;
            latch_q   <= latch_d;
            prev_q    <= intrqstsrc_i;
            data_q    <= data_d;
            for (int i = 0; i < INTSRCCOUNT; i++) begin
                prio_q[i] <= prio_d[i];
            end
        end
    end

    always_comb begin
        intrqstdst_o = '0;
        intrdysrc_o  = '1;
        if (state_q == ST_PEND) begin
            intrqstdst_o[dstidx_q] = 1'b1;
            if (!forced_q) begin
                intrdysrc_o[cursrc_q] = 1'b0;
            end
        end
    end

    assign pi1_data_o  = data_q;
    assign pi1_rdy_o   = 1'b1;
    assign pi1_mapsz_o = ARCHBITSZ'(MAPMUL * (ARCHBITSZ / 8));

endmodule

// File: tb/tb_intctrl_prio.sv
// tb/tb_intctrl_prio.sv - scoreboard bench for intctrl_prio
module tb_intctrl_prio;

    localparam int NS = 8;
    localparam int ND = 4;
    localparam logic [31:0] NEG1 = 32'hFFFF_FFFF;
    localparam logic [31:0] NEG2 = 32'hFFFF_FFFE;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    op;
    logic [29:0]   addr;
    logic [31:0]   wdata;
    logic [31:0]   rdata;
    logic [3:0]    sel;
    logic          rdy;
    logic [31:0]   mapsz;
    logic [ND-1:0] rqdst;
    logic [ND-1:0] rdydst;
    logic [ND-1:0] bestdst;
    logic [NS-1:0] rqsrc;
    logic [NS-1:0] rdysrc;

    int n_pass  = 0;
    int n_total = 0;
    int exp_src_q[$];
    int exp_dst_q[$];

    always #5 clk = ~clk;

    intctrl_prio #(
        .ARCHBITSZ  (32),
        .INTSRCCOUNT(NS),
        .INTDSTCOUNT(ND),
        .PRIOBITSZ  (2)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .pi1_op_i    (op),
        .pi1_addr_i  (addr),
        .pi1_data_i  (wdata),
        .pi1_data_o  (rdata),
        .pi1_sel_i   (sel),
        .pi1_rdy_o   (rdy),
        .pi1_mapsz_o (mapsz),
        .intrqstdst_o(rqdst),
        .intrdydst_i (rdydst),
        .intbestdst_i(bestdst),
        .intrqstsrc_i(rqsrc),
        .intrdysrc_o (rdysrc)
    );

    function automatic logic [31:0] w_ack(input int dst, input bit en);
        return (32'(dst) << 4) | (32'(en) << 3);
    endfunction

    function automatic logic [31:0] w_intdst(input int dst);
        return (32'(dst) << 3) | 32'd1;
    endfunction

    function automatic logic [31:0] w_cfg(input int idx, input bit en, input bit edg, input int prio);
        return (32'(idx) << 7) | (32'(en) << 6) | (32'(edg) << 5) | (32'(prio & 3) << 3) | 32'd2;
    endfunction

    task automatic do_cmd(input logic [31:0] w, output logic [31:0] r);
        @(negedge clk);
        op    = 2'b11;
        wdata = w;
        @(negedge clk);
        op    = 2'b00;
        wdata = '0;
        r     = rdata;
    endtask

    task automatic serve(input int dst, output logic [ND-1:0] req,
                         output logic [NS-1:0] rs, output logic [31:0] res);
        for (int c = 0; c < 20; c++) begin
            if (rqdst != '0) break;
            @(negedge clk);
        end
        req = rqdst;
        rs  = rdysrc;
        do_cmd(w_ack(dst, 1'b1), res);
    endtask

    task automatic test_reset();
        n_total++; if (rdata !== 32'd0) $display("FAIL reset_data got %h exp %h", rdata, 32'd0); else n_pass++;
        n_total++; if (rqdst !== '0) $display("FAIL reset_rqdst got %b exp %b", rqdst, 4'b0); else n_pass++;
        n_total++; if (rdysrc !== '1) $display("FAIL reset_rdysrc got %b exp %b", rdysrc, 8'hFF); else n_pass++;
        n_total++; if (rdy !== 1'b1) $display("FAIL reset_rdy got %b exp 1", rdy); else n_pass++;
        n_total++; if (mapsz !== 32'd8) $display("FAIL reset_mapsz got %0d exp 8", mapsz); else n_pass++;
    endtask

    task automatic test_basic();
        logic [31:0] r;
        logic [NS-1:0] ers;
        int cyc;
        do_cmd(w_ack(0, 1'b1), r);
        n_total++; if (r !== NEG2) $display("FAIL basic_ack_idle got %h exp %h", r, NEG2); else n_pass++;
        do_cmd(w_cfg(2, 1'b1, 1'b0, 1), r);
        n_total++; if (r !== 32'd2) $display("FAIL basic_cfg got %h exp %h", r, 32'd2); else n_pass++;
        rqsrc[2] = 1'b1;
        exp_src_q.push_back(2);
        exp_dst_q.push_back(0);
        cyc = 0;
        while (rqdst == '0 && cyc < 3) begin
            @(negedge clk);
            cyc++;
        end
        n_total++; if (rqdst !== 4'b0001) $display("FAIL basic_rqdst got %b exp %b", rqdst, 4'b0001); else n_pass++;
        ers = '1;
        ers[exp_src_q[0]] = 1'b0;
        n_total++; if (rdysrc !== ers) $display("FAIL basic_rdysrc got %b exp %b", rdysrc, ers); else n_pass++;
        do_cmd(w_ack(exp_dst_q.pop_front(), 1'b1), r);
        n_total++; if (r !== 32'(exp_src_q[0])) $display("FAIL basic_ack got %h exp %h", r, 32'(exp_src_q[0])); else n_pass++;
        void'(exp_src_q.pop_front());
        n_total++; if (rdysrc !== '1 || rqdst !== '0) $display("FAIL basic_release got %b/%b exp ff/0", rdysrc, rqdst); else n_pass++;
        rqsrc[2] = 1'b0;
        do_cmd(w_cfg(2, 1'b0, 1'b0, 0), r);
    endtask

    task automatic test_priority();
        logic [31:0] r;
        logic [ND-1:0] req, ereq;
        logic [NS-1:0] rs, ers;
        int es, ed;
        do_cmd(w_cfg(1, 1'b1, 1'b0, 0), r);
        do_cmd(w_cfg(5, 1'b1, 1'b0, 3), r);
        rqsrc[1] = 1'b1;
        rqsrc[5] = 1'b1;
        exp_src_q.push_back(5); exp_dst_q.push_back(0);
        exp_src_q.push_back(5); exp_dst_q.push_back(0);
        exp_src_q.push_back(1); exp_dst_q.push_back(0);
        for (int i = 0; i < 3; i++) begin
            serve(exp_dst_q[0], req, rs, r);
            es = exp_src_q.pop_front();
            ed = exp_dst_q.pop_front();
            ereq = '0; ereq[ed] = 1'b1;
            ers = '1;  ers[es] = 1'b0;
            n_total++; if (req !== ereq) $display("FAIL prio_req[%0d] got %b exp %b", i, req, ereq); else n_pass++;
            n_total++; if (rs !== ers) $display("FAIL prio_rdysrc[%0d] got %b exp %b", i, rs, ers); else n_pass++;
            n_total++; if (r !== 32'(es)) $display("FAIL prio_ack[%0d] got %h exp %h", i, r, 32'(es)); else n_pass++;
            if (i == 1) rqsrc[5] = 1'b0;
        end
        rqsrc[1] = 1'b0;
        do_cmd(w_cfg(1, 1'b0, 1'b0, 0), r);
        do_cmd(w_cfg(5, 1'b0, 1'b0, 0), r);
    endtask

    task automatic test_round_robin();
        logic [31:0] r;
        logic [ND-1:0] req;
        logic [NS-1:0] rs;
        int es;
        do_cmd(w_cfg(3, 1'b1, 1'b0, 2), r);
        do_cmd(w_cfg(6, 1'b1, 1'b0, 2), r);
        rqsrc[3] = 1'b1;
        rqsrc[6] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_src_q.push_back((i % 2 == 0) ? 3 : 6);
            exp_dst_q.push_back(0);
        end
        for (int i = 0; i < 4; i++) begin
            serve(exp_dst_q.pop_front(), req, rs, r);
            es = exp_src_q.pop_front();
            n_total++; if (r !== 32'(es)) $display("FAIL rr_order[%0d] got %h exp %h", i, r, 32'(es)); else n_pass++;
        end
        rqsrc[3] = 1'b0;
        rqsrc[6] = 1'b0;
        do_cmd(w_cfg(3, 1'b0, 1'b0, 0), r);
        do_cmd(w_cfg(6, 1'b0, 1'b0, 0), r);
    endtask

    task automatic test_edge();
        logic [31:0] r;
        logic [ND-1:0] req;
        logic [NS-1:0] rs;
        int es;
        do_cmd(w_cfg(4, 1'b1, 1'b1, 1), r);
        n_total++; if (r !== 32'd4) $display("FAIL edge_cfg got %h exp %h", r, 32'd4); else n_pass++;
        rqsrc[4] = 1'b1;
        @(negedge clk);
        rqsrc[4] = 1'b0;
        exp_src_q.push_back(4); exp_dst_q.push_back(0);
        for (int c = 0; c < 20; c++) begin
            if (rqdst != '0) break;
            @(negedge clk);
        end
        n_total++; if (rqdst !== 4'b0001) $display("FAIL edge_first_req got %b exp %b", rqdst, 4'b0001); else n_pass++;
        // new edge arrives in the very cycle of the acknowledge
        @(negedge clk);
        op       = 2'b11;
        wdata    = w_ack(exp_dst_q.pop_front(), 1'b1);
        rqsrc[4] = 1'b1;
        @(negedge clk);
        op       = 2'b00;
        wdata    = '0;
        rqsrc[4] = 1'b0;
        es = exp_src_q.pop_front();
        n_total++; if (rdata !== 32'(es)) $display("FAIL edge_first_ack got %h exp %h", rdata, 32'(es)); else n_pass++;
        exp_src_q.push_back(4); exp_dst_q.push_back(0);
        serve(exp_dst_q.pop_front(), req, rs, r);
        es = exp_src_q.pop_front();
        n_total++; if (r !== 32'(es)) $display("FAIL edge_rearm_ack got %h exp %h", r, 32'(es)); else n_pass++;
        repeat (5) @(negedge clk);
        n_total++; if (rqdst !== '0) $display("FAIL edge_latch_cleared got %b exp %b", rqdst, 4'b0); else n_pass++;
        do_cmd(w_cfg(4, 1'b0, 1'b1, 1), r);
        rqsrc[4] = 1'b1;
        @(negedge clk);
        rqsrc[4] = 1'b0;
        do_cmd(w_cfg(4, 1'b1, 1'b1, 1), r);
        repeat (5) @(negedge clk);
        n_total++; if (rqdst !== '0) $display("FAIL edge_disabled_pulse got %b exp %b", rqdst, 4'b0); else n_pass++;
        do_cmd(w_cfg(4, 1'b0, 1'b1, 1), r);
    endtask

    task automatic test_forced();
        logic [31:0] r;
        int cyc;
        do_cmd(w_intdst(2), r);
        n_total++; if (r !== 32'd2) $display("FAIL forced_ret got %h exp %h", r, 32'd2); else n_pass++;
        cyc = 0;
        while (rqdst == '0 && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        n_total++; if (rqdst !== 4'b0100) $display("FAIL forced_req got %b exp %b", rqdst, 4'b0100); else n_pass++;
        n_total++; if (cyc !== 2) $display("FAIL forced_seek_cycles got %0d exp 2", cyc); else n_pass++;
        n_total++; if (rdysrc !== '1) $display("FAIL forced_rdysrc got %b exp %b", rdysrc, 8'hFF); else n_pass++;
        do_cmd(w_intdst(1), r);
        n_total++; if (r !== NEG2) $display("FAIL forced_busy got %h exp %h", r, NEG2); else n_pass++;
        do_cmd(w_ack(1, 1'b1), r);
        n_total++; if (r !== NEG2) $display("FAIL forced_ack_wrong got %h exp %h", r, NEG2); else n_pass++;
        do_cmd(w_ack(2, 1'b0), r);
        n_total++; if (r !== NEG1) $display("FAIL forced_ack got %h exp %h", r, NEG1); else n_pass++;
        n_total++; if (rqdst !== '0) $display("FAIL forced_release got %b exp %b", rqdst, 4'b0); else n_pass++;
        do_cmd(w_intdst(ND), r);
        n_total++; if (r !== NEG1) $display("FAIL forced_range got %h exp %h", r, NEG1); else n_pass++;
        for (int c = 3; c < 8; c += 2) begin
            do_cmd(32'(c), r);
            n_total++; if (r !== NEG1) $display("FAIL bad_cmd%0d got %h exp %h", c, r, NEG1); else n_pass++;
        end
    endtask

    task automatic test_best();
        logic [31:0] r;
        logic [ND-1:0] req;
        logic [NS-1:0] rs;
        int es, ed;
        do_cmd(w_ack(1, 1'b1), r);
        bestdst = 4'b0010;
        do_cmd(w_cfg(0, 1'b1, 1'b0, 0), r);
        n_total++; if (r !== 32'd0) $display("FAIL best_cfg got %h exp %h", r, 32'd0); else n_pass++;
        rqsrc[0] = 1'b1;
        exp_src_q.push_back(0); exp_dst_q.push_back(1);
        serve(exp_dst_q[0], req, rs, r);
        es = exp_src_q.pop_front();
        ed = exp_dst_q.pop_front();
        n_total++; if (req !== 4'(1 << ed)) $display("FAIL best_req got %b exp %b", req, 4'(1 << ed)); else n_pass++;
        n_total++; if (r !== 32'(es)) $display("FAIL best_ack got %h exp %h", r, 32'(es)); else n_pass++;
        rqsrc[0] = 1'b0;
        bestdst  = '0;
        do_cmd(w_cfg(0, 1'b0, 1'b0, 0), r);
        do_cmd(w_cfg(NS, 1'b1, 1'b0, 1), r);
        n_total++; if (r !== NEG1) $display("FAIL cfg_range got %h exp %h", r, NEG1); else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [31:0] r;
        do_cmd(w_cfg(7, 1'b1, 1'b0, 2), r);
        rqsrc[7] = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (rqdst != '0) break;
            @(negedge clk);
        end
        n_total++; if (rqdst !== 4'b0001) $display("FAIL rstmid_req got %b exp %b", rqdst, 4'b0001); else n_pass++;
        rst = 1'b1;
        @(negedge clk);
        n_total++; if (rqdst !== '0) $display("FAIL rstmid_rqdst got %b exp %b", rqdst, 4'b0); else n_pass++;
        n_total++; if (rdysrc !== '1) $display("FAIL rstmid_rdysrc got %b exp %b", rdysrc, 8'hFF); else n_pass++;
        n_total++; if (rdata !== 32'd0) $display("FAIL rstmid_data got %h exp %h", rdata, 32'd0); else n_pass++;
        rst = 1'b0;
        repeat (4) @(negedge clk);
        n_total++; if (rqdst !== '0) $display("FAIL rstmid_src_disabled got %b exp %b", rqdst, 4'b0); else n_pass++;
        rqsrc[7] = 1'b0;
        do_cmd(w_ack(0, 1'b1), r);
        n_total++; if (r !== NEG2) $display("FAIL rstmid_no_pending got %h exp %h", r, NEG2); else n_pass++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst     = 1'b1;
        op      = 2'b00;
        addr    = '0;
        wdata   = '0;
        sel     = '0;
        rdydst  = '1;
        bestdst = '0;
        rqsrc   = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_basic();
        test_priority();
        test_round_robin();
        test_edge();
        test_forced();
        test_best();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
